sram_rw_arbiter: RTL and testbench

- Shares one single-port 128x14 SRAM macro (1RW, active-low CSB/WEB/OEB, registered read data, clocked by the system clock) between two requesters.
- Round-robin arbitration; each requester uses a valid/ready request channel and a valid/ready read-response channel.
- Drives all macro control, address and data pins and returns read data without extra buffering, because the macro's output register holds its value.
- Sits between the datapath clients and the SRAM macro instance in the lab SoC.

---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/sram_rw_arbiter_rr.sv | 28 ++
 rtl/sram_rw_arbiter.sv | 122 ++++++++++++
 tb/tb_sram_rw_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared widths, response state and request struct for the SRAM arbiter
package sram_arb_pkg;

  localparam int SRAM_ADDR_W = 7;
  localparam int SRAM_DATA_W = 14;
  localparam int NUM_REQ     = 2;

  typedef enum logic {
    RESP_IDLE,
    RESP_PENDING
  } resp_state_e;

  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_rw_arbiter_rr.sv
// rtl/sram_rw_arbiter_rr.sv - two-way round-robin grant; ineligible requesters never consume the pointer
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic [1:0] eligible,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       ptr_next
);

  logic [1:0] cand;

  always_comb begin
    cand     = valid & eligible;
    grant    = 2'b00;
    ptr_next = ptr;
    if (cand == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end else begin
      grant = cand;
    end
    if (grant[0]) begin
      ptr_next = 1'b1;
    end else if (grant[1]) begin
      ptr_next = 1'b0;
    end
  end

endmodule

// File: rtl/sram_rw_arbiter.sv
// rtl/sram_rw_arbiter.sv - round-robin sharing of a 1RW SRAM macro between two requesters
// Optional per-requester grant counters enabled by defining SRAM_ARB_PERF_EN.
module sram_rw_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int PERF_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic                  sram_oeb,
  output logic [ADDR_W-1:0]     sram_a,
  output logic [DATA_W-1:0]     sram_i,
  input  logic [DATA_W-1:0]     sram_o
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [2*PERF_W-1:0]   perf_grants
`endif
);

  resp_state_e       state, state_n;
  logic              owner, owner_n;
  logic              ptr, ptr_next;
  logic [1:0]        eligible, arb_grant, grant;
  logic              read_ok, any_grant, grant_idx, grant_we, read_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // A new read may only start when the single response slot is free or being freed now.
  assign read_ok  = (state == RESP_IDLE) || resp_ready[owner];
  assign eligible = req_we | {2{read_ok}};

  rr_arbiter2 u_rr (
    .valid    (req_valid),
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (arb_grant),
    .ptr_next (ptr_next)
  );

  always_comb begin
    grant      = arb_grant & {2{~reset}};
    any_grant  = |grant;
    grant_idx  = grant[1];
    grant_we   = req_we[grant_idx];
    read_grant = any_grant && !grant_we;
    req_ready  = grant;
    sram_csb   = ~any_grant;
    sram_web   = ~(any_grant && grant_we);
    sram_oeb   = ~read_grant;
    sram_a     = addr_q;
    sram_i     = wdata_q;
    if (any_grant) begin
      sram_a = req_addr[grant_idx*ADDR_W +: ADDR_W];
    end
    if (any_grant && grant_we) begin
      sram_i = req_wdata[grant_idx*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    if (read_grant) begin
      state_n = RESP_PENDING;
      owner_n = grant_idx;
    end else if (state == RESP_PENDING && resp_ready[owner]) begin
      state_n = RESP_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RESP_IDLE;
      owner   <= 1'b0;
      ptr     <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      ptr     <= ptr_next;
      addr_q  <= sram_a;
      wdata_q <= sram_i;
    end
  end

  // The macro output register holds the read value until the next read, so no copy is kept here.
  assign resp_valid = (state == RESP_PENDING) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign resp_rdata = sram_o;

`ifdef SRAM_ARB_PERF_EN
  logic [PERF_W-1:0] grant_cnt [2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt[0] <= '0;
      grant_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (req_ready[i] && grant_cnt[i] != {PERF_W{1'b1}}) begin
          grant_cnt[i] <= grant_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign perf_grants = {grant_cnt[1], grant_cnt[0]};
`endif

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// tb/tb_sram_rw_arbiter.sv - scoreboard bench for sram_rw_arbiter with a behavioural 1RW macro
module tb_sram_rw_arbiter;
  import sram_arb_pkg::*;

  localparam int AW = 7;
  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid, req_ready, req_we, resp_valid, resp_ready;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0] resp_rdata, sram_i, sram_o;
  logic [AW-1:0] sram_a;
  logic          sram_csb, sram_web, sram_oeb;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

`ifdef SRAM_ARB_PERF_EN
  logic [31:0] perf_grants;
  logic [3:0]  perf_small;
  logic [1:0]  s_ready, s_resp_valid;
  logic [DW-1:0] s_rdata, s_i;
  logic [AW-1:0] s_a;
  logic        s_csb, s_web, s_oeb;
`endif

  sram_rw_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .sram_csb   (sram_csb),
    .sram_web   (sram_web),
    .sram_oeb   (sram_oeb),
    .sram_a     (sram_a),
    .sram_i     (sram_i),
    .sram_o     (sram_o)
`ifdef SRAM_ARB_PERF_EN
    ,
    .perf_grants(perf_grants)
`endif
  );

`ifdef SRAM_ARB_PERF_EN
  sram_rw_arbiter #(.PERF_W(2)) dut_small (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (s_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (s_resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (s_rdata),
    .sram_csb   (s_csb),
    .sram_web   (s_web),
    .sram_oeb   (s_oeb),
    .sram_a     (s_a),
    .sram_i     (s_i),
    .sram_o     (sram_o),
    .perf_grants(perf_small)
  );
`endif

  // Behavioural macro: registered read data that holds until the next read.
  logic [DW-1:0] mem [0:127];
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) mem[sram_a] <= sram_i;
      else if (!sram_oeb) sram_o <= mem[sram_a];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic [1:0] v, input logic [1:0] we,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic [1:0] rr);
    req_valid  = v;
    req_we     = we;
    req_addr   = {a1, a0};
    req_wdata  = {d1, d0};
    resp_ready = rr;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && resp_valid != 2'b00) begin
      check("resp_onehot", 64'($countones(resp_valid)), 64'd1);
      if ((resp_valid & resp_ready) != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 64'(resp_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_owner", 64'(resp_valid), e.id ? 64'd2 : 64'd1);
          check("resp_rdata", 64'(resp_rdata), 64'(e.data));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    set_req(2'b00, 2'b00, '0, '0, '0, '0, 2'b00);
    sample;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_ctl", 64'({sram_csb, sram_web, sram_oeb}), 64'd7);
    check("rst_a", 64'(sram_a), 64'd0);
    check("rst_i", 64'(sram_i), 64'd0);
    next_cycle;
    reset = 1'b0;

    // Preload through the arbiter
    set_req(2'b01, 2'b01, 7'd1, '0, 14'h111, '0, 2'b00);
    sample; check("pre_w1_ready", 64'(req_ready), 64'd1);
    next_cycle;
    set_req(2'b10, 2'b10, '0, 7'd2, '0, 14'h222, 2'b00);
    sample; check("pre_w2_ready", 64'(req_ready), 64'd2);
    next_cycle;
    set_req(2'b01, 2'b01, 7'd3, '0, 14'h155, '0, 2'b00);
    sample; check("pre_w3_ready", 64'(req_ready), 64'd1);
    next_cycle;

    // Write then read back the same address, requester 0
    set_req(2'b01, 2'b01, 7'h7F, '0, 14'h2A5, '0, 2'b00);
    sample;
    check("wr_ready", 64'(req_ready), 64'd1);
    check("wr_ctl", 64'({sram_csb, sram_web, sram_oeb}), 64'b001);
    check("wr_a", 64'(sram_a), 64'h7F);
    check("wr_i", 64'(sram_i), 64'h2A5);
    next_cycle;
    set_req(2'b01, 2'b00, 7'h7F, '0, '0, '0, 2'b01);
    exp_q.push_back('{id: 1'b0, data: 14'h2A5});
    sample;
    check("rd_ready", 64'(req_ready), 64'd1);
    check("rd_ctl", 64'({sram_csb, sram_web, sram_oeb}), 64'b010);
    check("rd_resp_early", 64'(resp_valid), 64'd0);
    next_cycle;
    set_req(2'b00, 2'b00, '0, '0, '0, '0, 2'b01);
    sample;
    check("rd_resp_lat1", 64'(resp_valid), 64'd1);
    check("idle_ctl", 64'({sram_csb, sram_web, sram_oeb}), 64'b111);
    check("idle_a_hold", 64'(sram_a), 64'h7F);
    check("idle_i_hold", 64'(sram_i), 64'h2A5);
    next_cycle;

    // Reset with a read in flight
    set_req(2'b01, 2'b00, 7'd5, '0, '0, '0, 2'b00);
    sample; check("rstrd_ready", 64'(req_ready), 64'd1);
    next_cycle;
    reset = 1'b1;
    sample;
    check("rstrd_resp_valid", 64'(resp_valid), 64'd0);
    check("rstrd_ctl", 64'({sram_csb, sram_web, sram_oeb}), 64'd7);
    check("rstrd_ready0", 64'(req_ready), 64'd0);
    next_cycle;
    reset = 1'b0;
    set_req(2'b00, 2'b00, '0, '0, '0, '0, 2'b00);
    sample; check("rstrd_idle", 64'(resp_valid), 64'd0);
    next_cycle;
    set_req(2'b10, 2'b00, '0, 7'd1, '0, '0, 2'b10);
    exp_q.push_back('{id: 1'b1, data: 14'h111});
    sample; check("post_rst_grant", 64'(req_ready), 64'd2);
    next_cycle;
    set_req(2'b00, 2'b00, '0, '0, '0, '0, 2'b10);
    sample;
    next_cycle;

    // Contention: continuous reads from both, pointer at 0
    set_req(2'b11, 2'b00, 7'd1, 7'd2, '0, '0, 2'b11);
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back('{id: k[0], data: k[0] ? 14'h222 : 14'h111});
      sample;
      check("cont_grant", 64'(req_ready), k[0] ? 64'd2 : 64'd1);
      next_cycle;
    end
    set_req(2'b00, 2'b00, '0, '0, '0, '0, 2'b11);
    sample;
    next_cycle;

    // Backpressure on req0 while req1 writes then waits to read
    set_req(2'b01, 2'b00, 7'd3, '0, '0, '0, 2'b00);
    exp_q.push_back('{id: 1'b0, data: 14'h155});
    sample; check("bp_rd_grant", 64'(req_ready), 64'd1);
    next_cycle;
    set_req(2'b10, 2'b10, '0, 7'd9, '0, 14'h0AB, 2'b00);
    sample;
    check("bp_wr_grant", 64'(req_ready), 64'd2);
    check("bp_wr_web", 64'(sram_web), 64'd0);
    check("bp_hold_rdata", 64'(resp_rdata), 64'h155);
    next_cycle;
    for (int k = 0; k < 3; k++) begin
      set_req(2'b10, 2'b00, '0, 7'd9, '0, '0, 2'b00);
      sample;
      check("bp_stall_ready", 64'(req_ready), 64'd0);
      check("bp_stall_valid", 64'(resp_valid), 64'd1);
      check("bp_stall_rdata", 64'(resp_rdata), 64'h155);
      check("bp_stall_csb", 64'(sram_csb), 64'd1);
      next_cycle;
    end
    // Accept and re-grant in the same cycle
    set_req(2'b10, 2'b00, '0, 7'd9, '0, '0, 2'b01);
    exp_q.push_back('{id: 1'b1, data: 14'h0AB});
    sample;
    check("regrant_ready", 64'(req_ready), 64'd2);
    check("regrant_valid_old", 64'(resp_valid), 64'd1);
    next_cycle;
    set_req(2'b00, 2'b00, '0, '0, '0, '0, 2'b10);
    sample; check("regrant_valid_new", 64'(resp_valid), 64'd2);
    next_cycle;
    set_req(2'b00, 2'b00, '0, '0, '0, '0, 2'b00);
    sample; check("final_idle", 64'(resp_valid), 64'd0);
    next_cycle;

`ifdef SRAM_ARB_PERF_EN
    reset = 1'b1;
    sample; check("perf_rst", 64'(perf_grants), 64'd0);
    next_cycle;
    reset = 1'b0;
    set_req(2'b01, 2'b01, 7'd20, '0, 14'h1, '0, 2'b00);
    for (int k = 0; k < 10; k++) begin
      next_cycle;
      if (k == 4) check("perf_small_sat", 64'(perf_small), 64'h3);
    end
    set_req(2'b10, 2'b10, '0, 7'd21, '0, 14'h2, 2'b00);
    repeat (3) next_cycle;
    set_req(2'b00, 2'b00, '0, '0, '0, '0, 2'b00);
    sample;
    check("perf_counts", 64'(perf_grants), {32'd0, 16'd3, 16'd10});
    check("perf_small_both", 64'(perf_small), 64'hF);
    next_cycle;
`endif

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
